// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus plus word-RAM port of the memory access controller.
// Signal names follow the block's external pin names.
interface mem_access_ctrl_if;
  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic        Sign;
  logic [31:0] Addr;
  logic [31:0] W_Data;
  logic [31:0] R_Data;
  logic        Ready;
  logic        Err;
  logic        Busy;
  logic        Mem_W_En;
  logic [12:0] Mem_Addr;
  logic [31:0] Mem_D_In;
  logic [31:0] Mem_D_Out;

  // master = CPU plus RAM environment, slave = the controller
  modport master (
    output Req, Wr, Size, Sign, Addr, W_Data, Mem_D_Out,
    input  R_Data, Ready, Err, Busy, Mem_W_En, Mem_Addr, Mem_D_In
  );

  modport slave (
    input  Req, Wr, Size, Sign, Addr, W_Data, Mem_D_Out,
    output R_Data, Ready, Err, Busy, Mem_W_En, Mem_Addr, Mem_D_In
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/halfword/word load-store controller in front of a 32-bit word RAM with
// one-cycle read latency; sub-word stores are done as read-modify-write.
module mem_access_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WRITE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mdin_q, mdin_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misalign;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    misalign = (bus.Size == 2'b11)
             | ((bus.Size == 2'b01) & bus.Addr[0])
             | ((bus.Size == 2'b10) & (|bus.Addr[1:0]));
  end

  // Lane select and extension on load data; lane insert for read-modify-write.
  always_comb begin
    byte_lane  = bus.Mem_D_Out[{addr_q[1:0], 3'b000} +: 8];
    half_lane  = bus.Mem_D_Out[{addr_q[1], 4'b0000} +: 16];
    merge_data = bus.Mem_D_Out;
    case (size_q)
      2'b00:   load_data = {{24{sign_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{sign_q & half_lane[15]}}, half_lane};
      default: load_data = bus.Mem_D_Out;
    endcase
    if (size_q == 2'b00) begin
      merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case infers a latch.
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdin_d  = mdin_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          wr_d    = bus.Wr;
          size_d  = bus.Size;
          sign_d  = bus.Sign;
          addr_d  = bus.Addr[14:0];
          wdata_d = bus.W_Data[15:0];
          mdin_d  = bus.W_Data;
          err_d   = misalign;
          if (misalign) begin
            state_d = RESP;
          end else if (bus.Wr && (bus.Size == 2'b10)) begin
            state_d = WRITE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA: begin
        if (wr_q) begin
          mdin_d  = merge_data;
          state_d = WRITE;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all registers, including captured merge data, are cleared by reset
  // so the first access after release carries no stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdin_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdin_q  <= mdin_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write enable is a pure decode of WRITE so an async reset kills it at once.
  assign bus.Ready    = (state_q == RESP);
  assign bus.Err      = (state_q == RESP) & err_q;
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Mem_W_En = (state_q == WRITE);
  assign bus.Mem_Addr = addr_q[14:2];
  assign bus.Mem_D_In = mdin_q;
  assign bus.R_Data   = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a byte-level
// reference model of the word RAM and the access timing rules.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if ifc ();

  mem_access_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  logic [31:0] ram     [0:8191];
  logic [31:0] ref_mem [0:8191];
  logic [31:0] ref_rdata;
  logic [12:0] last_waddr;
  int          n_checks;
  int          n_fail;
  int          wen_cnt;
  int          ready_cnt;

  // Word RAM: synchronous write, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (ifc.Mem_W_En) begin
      ram[ifc.Mem_Addr] <= ifc.Mem_D_In;
      wen_cnt           <= wen_cnt + 1;
      last_waddr        <= ifc.Mem_Addr;
    end
    ifc.Mem_D_Out <= ram[ifc.Mem_Addr];
  end

  always @(negedge clk) begin
    if (ifc.Ready) ready_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU access: update the reference model, drive the request, and check
  // latency, error flag, load result, RAM writes and the return to idle.
  task automatic do_op(input logic wr, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic        mis;
    logic [12:0] idx;
    logic [31:0] word;
    logic [31:0] val;
    int          nbytes;
    int          exp_lat;
    int          exp_wen;
    int          start_wen;
    int          lat;
    bit          found;

    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    idx = addr[14:2];
    nbytes = 1 << size;
    if (mis)                   exp_lat = 1;
    else if (wr && size == 2)  exp_lat = 2;
    else if (!wr)              exp_lat = 3;
    else                       exp_lat = 4;
    exp_wen = (!mis && wr) ? 1 : 0;

    if (!mis) begin
      word = ref_mem[idx];
      if (wr) begin
        for (int i = 0; i < nbytes; i++) word[8*(addr[1:0]+i) +: 8] = wdata[8*i +: 8];
        ref_mem[idx] = word;
      end else begin
        val = '0;
        for (int i = 0; i < nbytes; i++) val[8*i +: 8] = word[8*(addr[1:0]+i) +: 8];
        if (sign && nbytes < 4 && val[8*nbytes-1])
          for (int i = nbytes; i < 4; i++) val[8*i +: 8] = 8'hFF;
        ref_rdata = val;
      end
    end

    @(negedge clk);
    ifc.Req    = 1'b1;
    ifc.Wr     = wr;
    ifc.Size   = size;
    ifc.Sign   = sign;
    ifc.Addr   = addr;
    ifc.W_Data = wdata;
    start_wen  = wen_cnt;
    @(posedge clk);
    lat   = 0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ifc.Req = 1'b0;
      lat++;
      if (ifc.Ready) begin
        found = 1;
        break;
      end
    end
    if (!found) lat = 99;

    check("latency", lat, exp_lat);
    check("err", {31'd0, ifc.Err}, {31'd0, mis});
    check("busy_resp", {31'd0, ifc.Busy}, 32'd1);
    check("r_data", ifc.R_Data, ref_rdata);
    check("wen_count", wen_cnt - start_wen, exp_wen);
    if (exp_wen == 1) check("waddr", {19'd0, last_waddr}, {19'd0, idx});
    check("ram_word", ram[idx], ref_mem[idx]);

    @(negedge clk);
    check("ready_pulse", {31'd0, ifc.Ready}, 32'd0);
    check("err_idle", {31'd0, ifc.Err}, 32'd0);
    check("busy_idle", {31'd0, ifc.Busy}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r0;

    for (int i = 0; i < 8192; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    ref_rdata  = '0;
    ifc.Req    = 1'b0;
    ifc.Wr     = 1'b0;
    ifc.Size   = 2'b00;
    ifc.Sign   = 1'b0;
    ifc.Addr   = '0;
    ifc.W_Data = '0;
    rst_n      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ifc.Ready}, 32'd0);
    check("rst_err", {31'd0, ifc.Err}, 32'd0);
    check("rst_busy", {31'd0, ifc.Busy}, 32'd0);
    check("rst_wen", {31'd0, ifc.Mem_W_En}, 32'd0);
    check("rst_rdata", ifc.R_Data, 32'd0);
    check("rst_maddr", {19'd0, ifc.Mem_Addr}, 32'd0);
    check("rst_mdin", ifc.Mem_D_In, 32'd0);
    rst_n = 1'b1;

    // Word store / word load round trip.
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    check("ws_ram", ram[4], 32'hDEADBEEF);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("wl_rdata", ifc.R_Data, 32'hDEADBEEF);

    // Byte store merges into a single lane.
    do_op(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000007F);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("bs_merge", ifc.R_Data, 32'hDE7FBEEF);

    // Byte load sign/zero extension from the top lane.
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FFFFFF);
    do_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    check("bl_sext", ifc.R_Data, 32'hFFFFFF80);
    do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    check("bl_zext", ifc.R_Data, 32'h00000080);

    // Misaligned accesses, including the illegal size.
    do_op(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    do_op(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678);
    do_op(1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678);
    check("mis_keep_rdata", ifc.R_Data, 32'h00000080);

    // Reset asserted while a byte store is in WRITE.
    @(negedge clk);
    ifc.Req    = 1'b1;
    ifc.Wr     = 1'b1;
    ifc.Size   = 2'd0;
    ifc.Sign   = 1'b0;
    ifc.Addr   = 32'h10;
    ifc.W_Data = 32'h55;
    @(posedge clk);
    @(negedge clk);
    ifc.Req = 1'b0;
    repeat (2) @(negedge clk);
    check("write_wen", {31'd0, ifc.Mem_W_En}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_wen", {31'd0, ifc.Mem_W_En}, 32'd0);
    check("abort_ready", {31'd0, ifc.Ready}, 32'd0);
    check("abort_err", {31'd0, ifc.Err}, 32'd0);
    check("abort_busy", {31'd0, ifc.Busy}, 32'd0);
    check("abort_rdata", ifc.R_Data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_ram", ram[4], 32'h80FFFFFF);
    check("abort_mdin", ifc.Mem_D_In, 32'd0);
    rst_n     = 1'b1;
    ref_rdata = '0;

    // First access after reset is a normal read-modify-write.
    do_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD);
    check("post_rst_ram", ram[4], 32'hABCDFFFF);

    // Req held high: accepted only in IDLE, one Ready per accepted load.
    do_op(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    r0 = ready_cnt;
    @(negedge clk);
    ifc.Req  = 1'b1;
    ifc.Wr   = 1'b0;
    ifc.Size = 2'd2;
    ifc.Addr = 32'h20;
    repeat (12) @(posedge clk);
    @(negedge clk);
    ifc.Req = 1'b0;
    repeat (6) @(negedge clk);
    check("held_req_readies", ready_cnt - r0, 32'd3);
    check("held_req_rdata", ifc.R_Data, 32'hCAFEF00D);
    ref_rdata = 32'hCAFEF00D;

    // Random traffic over low words and the top word, with random aliasing bits.
    for (int n = 0; n < 300; n++) begin
      a = ($urandom & 32'hFFFF8000) |
          (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31))
                                       : (32'h7FE0 + 32'($urandom_range(0, 31))));
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 Req  in  1  CPU access request, sampled only in IDLE.
REQ-005 Wr  in  1  1 = store, 0 = load.
REQ-006 Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 Sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 Addr  in  32  byte address; bits [31:15] ignored (aliasing).
REQ-009 W_Data  in  32  store data, right-justified for sub-word sizes.
REQ-010 R_Data  out  32  load result; holds its value until the next load completes.
REQ-011 Ready  out  1  one-cycle completion pulse.
REQ-012 Err  out  1  misalignment flag, valid while Ready=1.
REQ-013 Busy  out  1  high whenever the state is not IDLE.
REQ-014 Mem_W_En  out  1  word-RAM write enable.
REQ-015 Mem_Addr  out  13  word address = Addr[14:2] of the captured request.
REQ-016 Mem_D_In  out  32  word-RAM write data.
REQ-017 Mem_D_Out  in  32  word-RAM read data; valid the cycle after the address is presented with Mem_W_En=0.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_ISSUE, RD_DATA, WRITE and RESP.
REQ-019 In IDLE with Req=1, the block SHALL capture Wr, Size, Sign, Addr and W_Data.
REQ-020 Misalignment SHALL be: halfword with Addr[0]=1, word with Addr[1:0]!=00, or Size=11; a misaligned request SHALL go directly to RESP with Err=1, make no memory access and leave R_Data unchanged.
REQ-021 An aligned word store SHALL go IDLE->WRITE->RESP, with Mem_D_In=W_Data.
REQ-022 A load SHALL go IDLE->RD_ISSUE->RD_DATA->RESP; R_Data SHALL be registered on the RD_DATA->RESP edge.
REQ-023 A byte or halfword store SHALL go IDLE->RD_ISSUE->RD_DATA->WRITE->RESP (read-modify-write).
REQ-024 In RD_DATA of a sub-word store, the block SHALL register Mem_D_Out with only the target lane replaced by W_Data[7:0] or W_Data[15:0].
REQ-025 Lanes SHALL be little-endian: byte k occupies bits [8k+7:8k]; halfword at Addr[1]=h occupies bits [16h+15:16h].
REQ-026 Load extraction SHALL select the lane by the captured Addr[1:0] and extend to 32 bits per Sign; word loads SHALL ignore Sign.
REQ-027 Mem_W_En SHALL be a combinational decode of state==WRITE and SHALL be 0 in every other state.
REQ-028 Mem_Addr SHALL be driven from the captured address in all states.
REQ-029 Ready SHALL be 1 exactly in RESP; RESP SHALL always return to IDLE.
REQ-030 Req SHALL be ignored in every non-IDLE state, including RESP; back-to-back requests therefore incur one IDLE cycle.
REQ-031 Latency from the accepting edge to Ready high SHALL be: misaligned 1 cycle, word store 2, load 3, sub-word store 4.
REQ-032 Err SHALL be 0 whenever Ready=0.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state IDLE, Ready=0, Err=0, Busy=0, Mem_W_En=0, R_Data=0, and all captured registers 0.
REQ-034 Reset asserted mid-operation SHALL abort the access immediately; if asserted during WRITE before the clock edge, no RAM write SHALL occur.
REQ-035 The first request after reset release SHALL behave normally, with no residual merge data.

Verification
REQ-036 Word store Addr=0x10, W_Data=0xDEADBEEF, then word load at 0x10 -> Mem_W_En high for exactly 1 cycle at Mem_Addr=4; Ready at +2 and +3 cycles; R_Data=0xDEADBEEF.
REQ-037 Byte store 0x7F to Addr=0x12 over word 0xDEADBEEF, then word load -> RAM word=0xDE7FBEEF; store Ready at +4 cycles.
REQ-038 Byte load at 0x13 of word 0x80FFFFFF: Sign=1 -> R_Data=0xFFFFFF80; Sign=0 -> R_Data=0x00000080.
REQ-039 Halfword load at 0x11 and word store at 0x12 -> Ready with Err=1 at +1 cycle; Mem_W_En never asserted; R_Data unchanged.
REQ-040 rst_n driven low during the WRITE state of a byte store -> Mem_W_En drops the same cycle; RAM word unchanged; all outputs at reset values.
REQ-041 Req held high continuously -> requests accepted only in IDLE; exactly one Ready pulse per accepted request.
